divu_seq: RTL

Multi-cycle unsigned integer divider for the RV32 datapath. It sits directly downstream of the `sltu` comparator and reuses it each iteration as the restore/subtract decision. It is a restoring, one-quotient-bit-per-cycle divider with valid/ready handshakes on both sides, so the execute stage can stall on DIVU/REMU. Results follow RISC-V M-extension semantics, including the divide-by-zero case.

---
 rtl/divu_pkg.sv | 8 +
 rtl/adder_n.sv | 9 +
 rtl/sltu.sv | 8 +
 rtl/divu_seq.sv | 75 +++++++
 4 files changed

// File: rtl/divu_pkg.sv
// divu_pkg: shared state encoding and sizing helpers for the sequential unsigned divider
package divu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} divu_state_t;
  localparam int DIVU_N = 32;
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/adder_n.sv
// adder_n: N-bit adder with carry-in (a, b, c_in -> sum)
module adder_n #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
  output logic [N-1:0] sum
);
  assign sum = a + b + N'(c_in);
endmodule

// File: rtl/sltu.sv
// sltu: unsigned less-than comparator (a, b -> lt)
module sltu #(parameter int N = 32) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         lt
);
  assign lt = a < b;
endmodule

// File: rtl/divu_seq.sv
// divu_seq: restoring one-bit-per-cycle unsigned divider; in_valid/in_ready/dividend/divisor in, out_valid/out_ready/quotient/remainder/div_by_zero out
module divu_seq import divu_pkg::*; #(parameter int N = DIVU_N) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);
  localparam int CW = cnt_w(N);
  divu_state_t state, state_n;
  logic [N-1:0] q, q_n, dvs, dvs_n;
  logic [N:0] r, r_n, t, diff;
  logic [CW-1:0] cnt, cnt_n;
  logic dbz, dbz_n, lt, zero, unused;
  assign t = {r[N-1:0], q[N-1]};
  assign zero = divisor == '0;
  sltu #(.N(N+1)) u_sltu (.a(t), .b({1'b0, dvs}), .lt(lt));
  adder_n #(.N(N+1)) u_sub (.a(t), .b(~{1'b0, dvs}), .c_in(1'b1), .sum(diff));
  always_comb begin
    state_n = state;
    q_n = q;
    r_n = r;
    dvs_n = dvs;
    cnt_n = cnt;
    dbz_n = dbz;
    case (state)
      IDLE: if (in_valid) begin
        dvs_n = divisor;
        dbz_n = zero;
        q_n = zero ? '1 : dividend;
        r_n = zero ? {1'b0, dividend} : '0;
        cnt_n = CW'(N-1);
        state_n = zero ? DONE : BUSY;
      end
      BUSY: begin
        r_n = lt ? t : diff;
        q_n = {q[N-2:0], ~lt};
        cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
        state_n = (cnt == '0) ? DONE : BUSY;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      q <= '0;
      r <= '0;
      dvs <= '0;
      cnt <= '0;
      dbz <= 1'b0;
    end else begin
      state <= state_n;
      q <= q_n;
      r <= r_n;
      dvs <= dvs_n;
      cnt <= cnt_n;
      dbz <= dbz_n;
    end
  end
  // r[N] is always 0 between iterations since the subtract is gated by the compare
  assign unused = r[N];
  assign in_ready = (state == IDLE) & ~rst;
  assign out_valid = state == DONE;
  assign quotient = q;
  assign remainder = r[N-1:0];
  assign div_by_zero = dbz;
endmodule
